mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 512x32 synchronous RAM between the CPU control unit (port C) and the
//  program-loader/DMA engine (port D). Each port uses a req/ack handshake. The block sequences one
//  access at a time onto the RAM strobes (mem_read, mem_write, mem_enable). cpu_stall is fed to the
//  control unit's stop input, so the CPU FSM freezes while its access is pending.
// PARAMETERS
//  DATA_WIDTH    32  RAM word width
//  ADDR_WIDTH    9   RAM address width (512 words)
//  CPU_PRIORITY  0   1: CPU always wins a tie; 0: round-robin on a tie
// PORTS
//  clk        in   1   single system clock; all logic on posedge
//  reset      in   1   synchronous, active-low reset
//  cpu_req    in   1   CPU access request; held until cpu_ack
//  cpu_we     in   1   1 = write, 0 = read; stable while cpu_req is high
//  cpu_addr   in   AW  CPU word address
//  cpu_wdata  in   DW  CPU write data
//  cpu_rdata  out  DW  read data; valid in the cpu_ack cycle, held until next CPU read ack
//  cpu_ack    out  1   one-cycle completion pulse
//  cpu_stall  out  1   cpu_req & ~cpu_ack (combinational)
//  dma_req/dma_we/dma_addr/dma_wdata/dma_rdata/dma_ack   same as the CPU-side ports, for port D
//  mem_addr   out  AW  registered RAM address
//  mem_wdata  out  DW  registered RAM write data
//  mem_read   out  1   RAM read strobe
//  mem_write  out  1   RAM write strobe
//  mem_enable out  1   RAM enable = mem_read | mem_write
//  mem_rdata  in   DW  RAM read data, valid one cycle after the read strobe
//  owner      out  1   port of the access in flight (0 = CPU, 1 = DMA)
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - FSM states: IDLE -> GRANT -> DONE -> IDLE. Every access takes exactly 3 cycles: req sampled
//    in IDLE, strobes asserted in GRANT, ack asserted in DONE.
//  - IDLE: if no req, stay in IDLE. If one req, grant that port. If both req:
//      * CPU_PRIORITY = 1: grant the CPU.
//      * CPU_PRIORITY = 0: grant the port not in last_owner.
//    On a grant, latch owner, we, addr and wdata, then go to GRANT.
//  - GRANT: mem_addr/mem_wdata come from the latched values. mem_read = ~we, mem_write = we,
//    mem_enable = 1 for exactly this cycle. Next state is DONE.
//  - DONE: pulse the owner's ack. On a read, capture mem_rdata into the owner's rdata register.
//    Update last_owner. Next state is IDLE.
//  - Requester rule: at the edge that ends the ack cycle, the requester drops req or presents a new
//    request. A req seen in IDLE is always treated as a new access.
//  - Req dropped before ack is a protocol violation. The latched access still completes and still
//    acks.
//  - The non-owner's req is ignored while busy. It is never lost and is arbitrated on the next IDLE.
//  - Round-robin guarantee: under continuous requests from both ports, grants alternate C, D, C, D.
//    Worst-case wait is 6 cycles from req to ack.
//  - Reset (reset == 0 at posedge):
//      * state = IDLE; all strobes, acks, busy and owner = 0.
//      * cpu_rdata, dma_rdata, mem_addr and mem_wdata = 0.
//      * last_owner = DMA, so the CPU wins the first tie.
//      * Reset during GRANT suppresses the write (the strobe register clears), and no ack is issued.
//  - Address and data are passed through unmodified; there is no range check. Width is fixed by
//    the parameters.
// STRUCTURE
//  - Package mem_arb_pkg:
//      * state encoding: ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_DONE = 2'd2; 2'd3 is illegal and
//        recovers to IDLE.
//      * owner constants: OWN_CPU = 1'b0, OWN_DMA = 1'b1.
//  - Sub-module arb2_rr: 2-input tie-break logic (inputs: req_c, req_d, last_owner, prio;
//    output: winner). It is purely combinational; all other state lives in the top module.
// TESTING
//  1. Release reset; cpu_req=1, we=0, addr=9'h010, RAM[0x10]=32'hDEADBEEF
//     -> mem_read high in cycle 2, cpu_ack plus cpu_rdata=32'hDEADBEEF in cycle 3, cpu_stall
//        low in cycle 3.
//  2. dma_req=1, we=1, addr=9'h1FF, wdata=32'h12345678, then a CPU read of 0x1FF
//     -> mem_write for 1 cycle at 0x1FF; the CPU later reads 32'h12345678.
//  3. CPU_PRIORITY=0; cpu_req and dma_req both held high for 12 cycles
//     -> acks ordered C, D, C, D. No two acks on the same cycle. No port waits more than 6 cycles.
//  4. CPU_PRIORITY=1; both reqs held high
//     -> the CPU is granted every time and DMA is never acked (starvation is expected by design).
//  5. Assert reset=0 during the GRANT of a DMA write to 0x020 (old value 32'h0)
//     -> RAM[0x20] stays 32'h0, no dma_ack, busy=0 the next cycle.
//  6. cpu_req dropped in the GRANT cycle
//     -> the access still completes; cpu_ack pulses once; FSM back in IDLE with no re-issue.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the CPU/DMA memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2,
    ST_BAD   = 2'd3
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/arb2_rr.sv
// Two-port tie-break: fixed CPU priority or round-robin against the last owner.
module arb2_rr
  import mem_arb_pkg::*;
(
  input  logic req_c,
  input  logic req_d,
  input  logic last_owner,
  input  logic prio,
  output logic winner
);

  always_comb begin
    winner = OWN_CPU;
    if (req_c && req_d)
      winner = prio ? OWN_CPU : ~last_owner;
    else if (req_d)
      winner = OWN_DMA;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences CPU and DMA req/ack accesses onto one synchronous RAM, one 3-cycle access at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int CPU_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_stall,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_enable,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  owner,
  output logic                  busy
);

  state_e                state;
  logic                  we_q;
  logic                  last_owner;
  logic                  rd_q;
  logic                  wr_q;
  logic                  winner;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] dma_rdata_q;

  arb2_rr u_arb (
    .req_c      (cpu_req),
    .req_d      (dma_req),
    .last_owner (last_owner),
    .prio       (1'(CPU_PRIORITY != 0)),
    .winner     (winner)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      owner       <= OWN_CPU;
      we_q        <= 1'b0;
      last_owner  <= OWN_DMA;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_req || dma_req) begin
            owner <= winner;
            if (winner == OWN_DMA) begin
              we_q      <= dma_we;
              mem_addr  <= dma_addr;
              mem_wdata <= dma_wdata;
              rd_q      <= ~dma_we;
              wr_q      <= dma_we;
            end else begin
              we_q      <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              rd_q      <= ~cpu_we;
              wr_q      <= cpu_we;
            end
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (owner == OWN_DMA) dma_ack <= 1'b1;
          else                  cpu_ack <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (!we_q) begin
            if (owner == OWN_DMA) dma_rdata_q <= mem_rdata;
            else                  cpu_rdata_q <= mem_rdata;
          end
          last_owner <= owner;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are masked by reset so a reset landing in GRANT keeps the RAM from committing the write.
  assign mem_read   = rd_q & reset;
  assign mem_write  = wr_q & reset;
  assign mem_enable = mem_read | mem_write;

  // RAM data arrives in the ack cycle; bypass it so rdata is valid alongside the ack.
  assign cpu_rdata = (cpu_ack && !we_q) ? mem_rdata : cpu_rdata_q;
  assign dma_rdata = (dma_ack && !we_q) ? mem_rdata : dma_rdata_q;

  assign cpu_stall = cpu_req & ~cpu_ack;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural 512x32 synchronous RAM.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [8:0]  cpu_addr, dma_addr, mem_addr;
  logic [31:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        cpu_ack, dma_ack, cpu_stall, mem_read, mem_write, mem_enable, owner, busy;

  logic        p_cpu_req, p_dma_req;
  logic [8:0]  p_mem_addr;
  logic [31:0] p_cpu_rdata, p_dma_rdata, p_mem_wdata;
  logic [31:0] p_mem_rdata = 32'h0;
  logic        p_cpu_ack, p_dma_ack, p_cpu_stall, p_mem_read, p_mem_write, p_mem_enable;
  logic        p_owner, p_busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .CPU_PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_enable(mem_enable), .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .CPU_PRIORITY(1)) dut_prio (
    .clk(clk), .reset(reset),
    .cpu_req(p_cpu_req), .cpu_we(1'b0), .cpu_addr(9'h000), .cpu_wdata(32'h0),
    .cpu_rdata(p_cpu_rdata), .cpu_ack(p_cpu_ack), .cpu_stall(p_cpu_stall),
    .dma_req(p_dma_req), .dma_we(1'b0), .dma_addr(9'h001), .dma_wdata(32'h0),
    .dma_rdata(p_dma_rdata), .dma_ack(p_dma_ack),
    .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_read(p_mem_read),
    .mem_write(p_mem_write), .mem_enable(p_mem_enable), .mem_rdata(p_mem_rdata),
    .owner(p_owner), .busy(p_busy)
  );

  // Behavioural RAM: preloaded on the first edge, then one-cycle read latency.
  logic [31:0] ram [512];
  logic        ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 512; i++) ram[i] <= 32'h0;
      ram[9'h010] <= 32'hDEADBEEF;
      ram_ready   <= 1'b1;
    end else begin
      if (mem_enable && mem_write) ram[mem_addr] <= mem_wdata;
      if (mem_enable && mem_read)  mem_rdata <= ram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cpu_acks = 0;
  int dma_acks = 0;

  typedef struct {
    logic        port;
    logic        rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic port, input logic rd, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every ack is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && (cpu_ack || dma_ack)) begin
      check("single_ack", 32'(cpu_ack & dma_ack), 32'h0);
      if (cpu_ack) cpu_acks++;
      if (dma_ack) dma_acks++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: cpu_ack=%0d dma_ack=%0d, expected no ack", cpu_ack, dma_ack);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", 32'(dma_ack), 32'(e.port));
        if (e.rd) check("ack_rdata", dma_ack ? dma_rdata : cpu_rdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic port);
    int k;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (port ? dma_ack : cpu_ack) break;
    end
    if (k == 10) check("ack_timeout", 32'(k), 32'h0);
    tick();
    if (port) dma_req = 1'b0;
    else      cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int last_c, last_d, nc, nd, pc, pd, acks0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    p_cpu_req = 0; p_dma_req = 0;
    repeat (3) tick();
    check("rst_busy",      32'(busy), 32'h0);
    check("rst_owner",     32'(owner), 32'h0);
    check("rst_enable",    32'(mem_enable), 32'h0);
    check("rst_acks",      32'({cpu_ack, dma_ack}), 32'h0);
    check("rst_mem_addr",  32'(mem_addr), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_dma_rdata", dma_rdata, 32'h0);

    // CPU read of 0x010 straight out of reset
    reset = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
    push_exp(1'b0, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_stall_idle", 32'(cpu_stall), 32'h1);
    check("t1_read_idle",  32'(mem_read), 32'h0);
    @(negedge clk);
    check("t1_mem_read",   32'(mem_read), 32'h1);
    check("t1_mem_enable", 32'(mem_enable), 32'h1);
    check("t1_mem_addr",   32'(mem_addr), 32'h010);
    check("t1_busy",       32'(busy), 32'h1);
    @(negedge clk);
    check("t1_cpu_ack",    32'(cpu_ack), 32'h1);
    check("t1_stall_ack",  32'(cpu_stall), 32'h0);
    tick();
    cpu_req = 0;
    @(negedge clk);
    check("t1_rdata_held", cpu_rdata, 32'hDEADBEEF);
    check("t1_idle",       32'(busy), 32'h0);

    // DMA write to the top word, then CPU reads it back
    tick();
    dma_req = 1; dma_we = 1; dma_addr = 9'h1FF; dma_wdata = 32'h12345678;
    push_exp(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("t2_mem_write", 32'(mem_write), 32'h1);
    check("t2_mem_read",  32'(mem_read), 32'h0);
    check("t2_mem_addr",  32'(mem_addr), 32'h1FF);
    check("t2_mem_wdata", mem_wdata, 32'h12345678);
    check("t2_owner",     32'(owner), 32'h1);
    @(negedge clk);
    check("t2_write_once", 32'(mem_write), 32'h0);
    check("t2_dma_ack",    32'(dma_ack), 32'h1);
    tick();
    dma_req = 0;
    check("t2_ram", ram[9'h1FF], 32'h12345678);
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h1FF;
    push_exp(1'b0, 1'b1, 32'h12345678);
    wait_ack(1'b0);

    // Mid-run reset clears held read data and the address/data registers
    reset = 0;
    tick(); tick();
    check("rst2_cpu_rdata", cpu_rdata, 32'h0);
    check("rst2_mem_addr",  32'(mem_addr), 32'h0);
    check("rst2_mem_wdata", mem_wdata, 32'h0);
    check("rst2_busy",      32'(busy), 32'h0);

    // Both ports held: round-robin on dut, fixed CPU priority on dut_prio
    reset = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
    dma_req = 1; dma_we = 0; dma_addr = 9'h1FF;
    p_cpu_req = 1; p_dma_req = 1;
    push_exp(1'b0, 1'b1, 32'hDEADBEEF);
    push_exp(1'b1, 1'b1, 32'h12345678);
    push_exp(1'b0, 1'b1, 32'hDEADBEEF);
    push_exp(1'b1, 1'b1, 32'h12345678);
    last_c = 0; last_d = 0; nc = 0; nd = 0; pc = 0; pd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (cpu_ack) begin
        check("t3_cpu_wait_le6", 32'(k - last_c <= 6), 32'h1);
        last_c = k + 1; nc++;
      end
      if (dma_ack) begin
        check("t3_dma_wait_le6", 32'(k - last_d <= 6), 32'h1);
        last_d = k + 1; nd++;
      end
      if (p_cpu_ack) pc++;
      if (p_dma_ack) pd++;
    end
    cpu_req = 0; dma_req = 0; p_cpu_req = 0; p_dma_req = 0;
    check("t3_cpu_acks",  32'(nc), 32'd2);
    check("t3_dma_acks",  32'(nd), 32'd2);
    check("t4_prio_cpu",  32'(pc), 32'd4);
    check("t4_prio_dma",  32'(pd), 32'd0);
    repeat (4) tick();
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // Reset lands in the GRANT cycle of a DMA write
    dma_req = 1; dma_we = 1; dma_addr = 9'h020; dma_wdata = 32'hAAAA5555;
    @(negedge clk);
    tick();
    check("t5_in_grant", 32'(busy), 32'h1);
    reset = 0; dma_req = 0;
    @(negedge clk);
    check("t5_write_masked", 32'(mem_enable), 32'h0);
    @(negedge clk);
    check("t5_busy_after", 32'(busy), 32'h0);
    check("t5_no_ack",     32'(dma_ack), 32'h0);
    check("t5_ram",        ram[9'h020], 32'h0);
    reset = 1;
    repeat (3) tick();

    // CPU drops req during GRANT: access completes exactly once
    acks0 = cpu_acks;
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
    push_exp(1'b0, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    tick();
    cpu_req = 0;
    repeat (6) tick();
    check("t6_one_ack", 32'(cpu_acks - acks0), 32'd1);
    check("t6_idle",    32'(busy), 32'h0);
    check("t6_no_strobe", 32'(mem_enable), 32'h0);

    check("end_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
